// File: rtl/tone_i2s_pkg.sv
// Shared types and defaults for the stereo tone I2S transmitter.
// Optional sawtooth generation is enabled with TONE_I2S_SAW_EN.
package tone_i2s_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int PERIOD_W_DEF = 16;
  localparam int SCLK_DIV_DEF = 2;

  typedef enum logic {
    SQUARE = 1'b0,
    SAW    = 1'b1
  } wave_mode_e;

  // One I2S frame carries a left and a right word.
  function automatic int frame_bits(input int sample_w);
    return 2 * sample_w;
  endfunction

endpackage

// File: rtl/tone_i2s_tx_chan.sv
// One tone channel: shadow period, phase counter and sample generation.
// Sawtooth accumulator exists only when TONE_I2S_SAW_EN is defined.
module tone_chan
  import tone_i2s_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                frame_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [SAMPLE_W-2:0] amp_i,
  input  wave_mode_e          wave_i,
  output logic [SAMPLE_W-1:0] sample_o
);

  logic [PERIOD_W-1:0] shadow_q, shadow_d;
  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic [PERIOD_W:0]   step;
  logic [PERIOD_W-1:0] half;
  logic [SAMPLE_W-1:0] mag;
  logic [SAMPLE_W-1:0] sq_sample;

  // Phase advances once per frame against the period in force for that
  // frame; the newly latched period then restarts phase if it is too short.
  always_comb begin
    shadow_d = shadow_q;
    phase_d  = phase_q;
    step     = {1'b0, phase_q} + (PERIOD_W+1)'(1);
    if (clr_i) begin
      shadow_d = '0;
      phase_d  = '0;
    end else if (frame_i) begin
      shadow_d = period_i;
      if (shadow_q < PERIOD_W'(2)) begin
        phase_d = '0;
      end else if (step >= {1'b0, period_i}) begin
        phase_d = '0;
      end else begin
        phase_d = step[PERIOD_W-1:0];
      end
    end
  end

  // Period shadow and phase state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      phase_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      phase_q  <= phase_d;
    end
  end

  // Square level: +amp for the first floor(P/2) frames, -amp after.
  always_comb begin
    mag  = {1'b0, amp_i};
    half = shadow_q >> 1;
    if (shadow_q < PERIOD_W'(2)) begin
      sq_sample = '0;
    end else if (phase_q < half) begin
      sq_sample = mag;
    end else begin
      sq_sample = '0 - mag;
    end
  end

`ifdef TONE_I2S_SAW_EN
  logic [SAMPLE_W-1:0] acc_q, acc_d;

  // Accumulator is held at zero outside saw mode, so entering saw starts at 0.
  always_comb begin
    acc_d = acc_q;
    if (clr_i || wave_i != SAW) begin
      acc_d = '0;
    end else if (frame_i) begin
      acc_d = acc_q + mag;
    end
  end

  // Sawtooth accumulator register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign sample_o = (wave_i == SAW) ? acc_q : sq_sample;
`else
  logic unused_wave;
  assign unused_wave = (wave_i == SAW);
  assign sample_o    = sq_sample;
`endif

endmodule

// File: rtl/tone_i2s_tx.sv
// Stereo tone generator with I2S master transmitter (mclk/sclk/lrclk/sdin).
// Define TONE_I2S_SAW_EN to let mode[0]/mode[1] select sawtooth per channel.
module tone_i2s_tx
  import tone_i2s_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int SCLK_DIV = SCLK_DIV_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period_l,
  input  logic [PERIOD_W-1:0] period_r,
  input  logic [SAMPLE_W-2:0] amp_l,
  input  logic [SAMPLE_W-2:0] amp_r,
  input  logic [1:0]          mode,
  output logic                mclk,
  output logic                sclk,
  output logic                lrclk,
  output logic                sdin,
  output logic                frame_strobe
);

  localparam int FRAME_W = frame_bits(SAMPLE_W);
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] BIT_LR   = BIT_W'(SAMPLE_W);

  logic               mclk_q, mclk_d;
  logic               sclk_q, sclk_d;
  logic               lrclk_q, lrclk_d;
  logic               sdin_q, sdin_d;
  logic               strobe_q, strobe_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;

  logic               div_wrap;
  logic               fall;
  logic               wrap;
  logic [SAMPLE_W-1:0] sample_l;
  logic [SAMPLE_W-1:0] sample_r;
  wave_mode_e         wave_l;
  wave_mode_e         wave_r;

`ifdef TONE_I2S_SAW_EN
  assign wave_l = mode[0] ? SAW : SQUARE;
  assign wave_r = mode[1] ? SAW : SQUARE;
`else
  logic unused_mode;
  assign unused_mode = ^mode;
  assign wave_l      = SQUARE;
  assign wave_r      = SQUARE;
`endif

  // Fall edge is the clk where sclk goes 1->0; wrap is the frame start.
  always_comb begin
    div_wrap = (div_q == DIV_LAST);
    fall     = div_wrap && sclk_q;
    wrap     = fall && (bit_q == BIT_LAST);
  end

  // Clock divider, bit counter and serializer; the shift register keeps
  // shifting through the wrap so the previous right LSB fills slot 0.
  always_comb begin
    mclk_d   = mclk_q;
    sclk_d   = sclk_q;
    lrclk_d  = lrclk_q;
    sdin_d   = sdin_q;
    strobe_d = 1'b0;
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    if (!enable) begin
      mclk_d  = 1'b0;
      sclk_d  = 1'b0;
      lrclk_d = 1'b0;
      sdin_d  = 1'b0;
      div_d   = '0;
      bit_d   = '0;
      shreg_d = '0;
    end else begin
      mclk_d = ~mclk_q;
      div_d  = div_wrap ? '0 : div_q + DIV_W'(1);
      if (div_wrap) begin
        sclk_d = ~sclk_q;
      end
      if (fall) begin
        bit_d    = wrap ? '0 : bit_q + BIT_W'(1);
        lrclk_d  = (bit_d >= BIT_LR);
        sdin_d   = shreg_q[FRAME_W-1];
        strobe_d = wrap;
        if (wrap) begin
          shreg_d = {sample_l, sample_r};
        end else begin
          shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
        end
      end
    end
  end

  // Transmitter state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mclk_q   <= 1'b0;
      sclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
      sdin_q   <= 1'b0;
      strobe_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
    end else begin
      mclk_q   <= mclk_d;
      sclk_q   <= sclk_d;
      lrclk_q  <= lrclk_d;
      sdin_q   <= sdin_d;
      strobe_q <= strobe_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
    end
  end

  tone_chan #(
    .SAMPLE_W(SAMPLE_W),
    .PERIOD_W(PERIOD_W)
  ) u_chan_l (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (!enable),
    .frame_i (wrap),
    .period_i(period_l),
    .amp_i   (amp_l),
    .wave_i  (wave_l),
    .sample_o(sample_l)
  );

  tone_chan #(
    .SAMPLE_W(SAMPLE_W),
    .PERIOD_W(PERIOD_W)
  ) u_chan_r (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (!enable),
    .frame_i (wrap),
    .period_i(period_r),
    .amp_i   (amp_r),
    .wave_i  (wave_r),
    .sample_o(sample_r)
  );

  assign mclk         = mclk_q;
  assign sclk         = sclk_q;
  assign lrclk        = lrclk_q;
  assign sdin         = sdin_q;
  assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_tone_i2s_tx.sv
// Directed bench for tone_i2s_tx (SAMPLE_W=16, SCLK_DIV=2).
// Expected saw words are used when TONE_I2S_SAW_EN is defined.
module tb_tone_i2s_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] period_l, period_r;
  logic [14:0] amp_l, amp_r;
  logic [1:0]  mode;
  logic        mclk, sclk, lrclk, sdin, frame_strobe;

  int total = 0;
  int bad   = 0;

  tone_i2s_tx #(
    .SAMPLE_W(16),
    .SCLK_DIV(2),
    .PERIOD_W(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .period_l    (period_l),
    .period_r    (period_r),
    .amp_l       (amp_l),
    .amp_r       (amp_r),
    .mode        (mode),
    .mclk        (mclk),
    .sclk        (sclk),
    .lrclk       (lrclk),
    .sdin        (sdin),
    .frame_strobe(frame_strobe)
  );

  always #5 clk = ~clk;

  // I2S receiver: sample sdin on each sclk rise; a word ends on the
  // slot where lrclk changes (one-bit delay).
  logic [15:0] sh;
  logic        prev_lr;
  logic        prev_sclk;
  logic [15:0] ql[$];
  logic [15:0] qr[$];

  always @(negedge clk) begin
    if (reset || !enable) begin
      sh        = '0;
      prev_lr   = 1'b0;
      prev_sclk = 1'b0;
    end else begin
      if (sclk && !prev_sclk) begin
        if (lrclk != prev_lr) begin
          if (prev_lr) qr.push_back({sh[14:0], sdin});
          else         ql.push_back({sh[14:0], sdin});
        end
        sh      = {sh[14:0], sdin};
        prev_lr = lrclk;
      end
      prev_sclk = sclk;
    end
  end

  typedef struct {
    logic [15:0]        pl;
    logic [15:0]        pr;
    logic [14:0]        al;
    logic [14:0]        ar;
    logic [1:0]         md;
    logic [0:7][15:0]   el;
    logic [0:7][15:0]   er;
  } vec_t;

  vec_t v [6];

  function automatic vec_t mkv(
    input logic [15:0] pl, pr,
    input logic [14:0] al, ar,
    input logic [1:0] md,
    input logic [0:7][15:0] el, er
  );
    vec_t r;
    r.pl = pl; r.pr = pr;
    r.al = al; r.ar = ar;
    r.md = md;
    r.el = el; r.er = er;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lw(input int k);
    return (k < ql.size()) ? ql[k] : 16'hxxxx;
  endfunction

  function automatic logic [15:0] rw(input int k);
    return (k < qr.size()) ? qr[k] : 16'hxxxx;
  endfunction

  function automatic logic [4:0] outs();
    return {mclk, sclk, lrclk, sdin, frame_strobe};
  endfunction

  task automatic wait_words(input int n);
    int cyc = 0;
    while ((ql.size() < n || qr.size() < n) && cyc < (n + 2) * 128) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (ql.size() < n || qr.size() < n) begin
      bad++;
      $display("FAIL words timeout: got L=%0d R=%0d want %0d", ql.size(), qr.size(), n);
    end
  endtask

  task automatic wait_strobes(input int n);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < n * 128 + 200) begin
      @(negedge clk);
      cyc++;
      if (frame_strobe) seen++;
    end
    total++;
    if (seen < n) begin
      bad++;
      $display("FAIL strobe timeout: got %0d want %0d", seen, n);
    end
  endtask

  // Caller has just released reset or raised enable at a negedge.
  task automatic release_check(input string tag);
    for (int n = 1; n <= 256; n++) begin
      @(negedge clk);
      if (n <= 8) begin
        chk($sformatf("%s mclk@%0d", tag, n), 32'(mclk), 32'(n % 2));
        chk($sformatf("%s sclk@%0d", tag, n), 32'(sclk), 32'((n / 2) % 2));
      end
      if (n == 63)  chk({tag, " lrclk@63"}, 32'(lrclk), 32'd0);
      if (n == 64)  chk({tag, " lrclk@64"}, 32'(lrclk), 32'd1);
      if (n == 127) chk({tag, " strobe@127"}, 32'(frame_strobe), 32'd0);
      if (n == 128) chk({tag, " strobe@128"}, 32'(frame_strobe), 32'd1);
      if (n == 129) chk({tag, " strobe@129"}, 32'(frame_strobe), 32'd0);
      if (n == 255) chk({tag, " strobe@255"}, 32'(frame_strobe), 32'd0);
      if (n == 256) chk({tag, " strobe@256"}, 32'(frame_strobe), 32'd1);
    end
  endtask

  task automatic restart();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    ql.delete();
    qr.delete();
    enable = 1'b1;
  endtask

  task automatic goto_bit20();
    wait_strobes(1);
    repeat (80) @(negedge clk);
    chk("bit20 lrclk", 32'(lrclk), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    v[0] = mkv(16'd4, 16'd0, 15'h1000, 15'h0000, 2'b00,
      {16'h0000, 16'h0000, 16'h1000, 16'h1000, 16'hF000, 16'hF000, 16'h1000, 16'h1000},
      {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    v[1] = mkv(16'd6, 16'd2, 15'h7FFF, 15'h0001, 2'b00,
      {16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8001, 16'h8001, 16'h8001},
      {16'h0000, 16'h0000, 16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF});
    v[2] = mkv(16'd3, 16'd1, 15'h0100, 15'h1234, 2'b00,
      {16'h0000, 16'h0000, 16'h0100, 16'hFF00, 16'hFF00, 16'h0100, 16'hFF00, 16'hFF00},
      {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    v[3] = mkv(16'd8, 16'd0, 15'h0000, 15'h1234, 2'b00,
      {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
      {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
`ifdef TONE_I2S_SAW_EN
    v[4] = mkv(16'd4, 16'd2, 15'h4000, 15'h0010, 2'b01,
      {16'h0000, 16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h4000, 16'h8000},
      {16'h0000, 16'h0000, 16'h0010, 16'hFFF0, 16'h0010, 16'hFFF0, 16'h0010, 16'hFFF0});
    v[5] = mkv(16'd2, 16'd5, 15'h0001, 15'h6000, 2'b10,
      {16'h0000, 16'h0000, 16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF},
      {16'h0000, 16'h0000, 16'h6000, 16'hC000, 16'h2000, 16'h8000, 16'hE000, 16'h4000});
`else
    v[4] = mkv(16'd4, 16'd2, 15'h4000, 15'h0010, 2'b01,
      {16'h0000, 16'h0000, 16'h4000, 16'h4000, 16'hC000, 16'hC000, 16'h4000, 16'h4000},
      {16'h0000, 16'h0000, 16'h0010, 16'hFFF0, 16'h0010, 16'hFFF0, 16'h0010, 16'hFFF0});
    v[5] = mkv(16'd2, 16'd5, 15'h0001, 15'h6000, 2'b10,
      {16'h0000, 16'h0000, 16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF},
      {16'h0000, 16'h0000, 16'h6000, 16'h6000, 16'hA000, 16'hA000, 16'hA000, 16'h6000});
`endif

    reset    = 1'b1;
    enable   = 1'b1;
    period_l = 16'd0;
    period_r = 16'd0;
    amp_l    = '0;
    amp_r    = '0;
    mode     = 2'b00;

    // Power-on reset held 10 clk, then timing of the first frames.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("reset outs@%0d", i), 32'(outs()), 32'd0);
    end
    reset = 1'b0;
    release_check("por");

    // Table of steady-state tone vectors.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      enable   = 1'b0;
      period_l = v[i].pl;
      period_r = v[i].pr;
      amp_l    = v[i].al;
      amp_r    = v[i].ar;
      mode     = v[i].md;
      @(negedge clk);
      ql.delete();
      qr.delete();
      enable = 1'b1;
      wait_words(8);
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("v%0d L%0d", i, k), 32'(lw(k)), 32'(v[i].el[k]));
        chk($sformatf("v%0d R%0d", i, k), 32'(rw(k)), 32'(v[i].er[k]));
      end
    end

    // Left period 8 -> 2 in frame 6 (phase 5): change lands at frame end.
    period_l = 16'd8;
    amp_l    = 15'h1000;
    period_r = 16'd0;
    amp_r    = 15'h0000;
    mode     = 2'b00;
    restart();
    wait_strobes(6);
    repeat (64) @(negedge clk);
    period_l = 16'd2;
    wait_words(11);
    chk("pchg L5",  32'(lw(5)),  32'h1000);
    chk("pchg L6",  32'(lw(6)),  32'hF000);
    chk("pchg L7",  32'(lw(7)),  32'hF000);
    chk("pchg L8",  32'(lw(8)),  32'h1000);
    chk("pchg L9",  32'(lw(9)),  32'hF000);
    chk("pchg L10", 32'(lw(10)), 32'h1000);

    // Right period 1 holds phase at 0; switching to 4 starts from phase 0.
    period_l = 16'd0;
    amp_l    = 15'h0000;
    period_r = 16'd1;
    amp_r    = 15'h1000;
    restart();
    wait_strobes(3);
    repeat (64) @(negedge clk);
    period_r = 16'd4;
    wait_words(9);
    chk("p1 R3", 32'(rw(3)), 32'h0000);
    chk("p1 R4", 32'(rw(4)), 32'h0000);
    chk("p1 R5", 32'(rw(5)), 32'h1000);
    chk("p1 R6", 32'(rw(6)), 32'h1000);
    chk("p1 R7", 32'(rw(7)), 32'hF000);
    chk("p1 R8", 32'(rw(8)), 32'hF000);

    // Asynchronous reset pulse at bit_cnt 20.
    goto_bit20();
    #2 reset = 1'b1;
    #1 chk("async rst outs", 32'(outs()), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst hold outs", 32'(outs()), 32'd0);
    reset = 1'b0;
    release_check("rst2");

    // Enable drop at bit_cnt 20 clears synchronously; restart from bit 0.
    goto_bit20();
    enable = 1'b0;
    @(negedge clk);
    chk("en drop outs", 32'(outs()), 32'd0);
    enable = 1'b1;
    release_check("en");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
